// File: rtl/cgra_cfg_pkg.sv
// Shared definitions for the CGRA configuration path: FSM encoding, beat geometry
// and the odd-parity check used on assembled context words.
package cgra_cfg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam int BEATS_PER_CTX = 4;
  localparam int BEAT_W        = 32;
  localparam int WORD_W        = BEATS_PER_CTX * BEAT_W;
  localparam int DEFAULT_WIDTH = 120;
  localparam int CTX_W         = DEFAULT_WIDTH + 1;
  localparam int PARITY_BIT    = 127;

  // True when the parity bit plus bits [msb:0] hold an odd number of ones.
  function automatic logic ctx_parity_ok(input logic [WORD_W-1:0] word, input int msb);
    logic acc;
    acc = word[PARITY_BIT];
    for (int i = 0; i < PARITY_BIT; i++) begin
      if (i <= msb) acc = acc ^ word[i];
    end
    return acc;
  endfunction

endpackage

// File: rtl/ctx_beat_assembler.sv
// Collects four 32-bit config beats (least significant first) into one 128-bit word.
// word_done flags the handshake that completes the word.
module ctx_beat_assembler
  import cgra_cfg_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clr,
  input  logic              beat_en,
  input  logic [BEAT_W-1:0] beat_data,
  output logic              word_done,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0] slot_q [BEATS_PER_CTX];
  logic [BEAT_W-1:0] slot_d [BEATS_PER_CTX];

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (clr) begin
      beat_cnt_d = '0;
    end else if (beat_en) begin
      beat_cnt_d = beat_cnt_q + 2'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < BEATS_PER_CTX; i++) slot_d[i] = slot_q[i];
    if (beat_en) slot_d[beat_cnt_q] = beat_data;
  end

  assign word_done = beat_en && (beat_cnt_q == 2'(BEATS_PER_CTX - 1));

  always_comb begin
    word = '0;
    for (int i = 0; i < BEATS_PER_CTX; i++) word[i*BEAT_W +: BEAT_W] = slot_q[i];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) beat_cnt_q <= '0;
    else     beat_cnt_q <= beat_cnt_d;
  end

  // Payload slots carry no reset; they are always fully rewritten before use.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < BEATS_PER_CTX; i++) slot_q[i] <= slot_d[i];
  end

endmodule

// File: rtl/context_loader.sv
// Streams config beats into PE context caches in PE-major order, then pulses start.
// Optional CTX_PARITY_EN: bit 127 of each word is odd parity; bad words are dropped.
module context_loader
  import cgra_cfg_pkg::*;
#(
  parameter int WIDTH     = 120,
  parameter int NUM_PE    = 16,
  parameter int CTX_DEPTH = 16,
  parameter int CTX_AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_req,
  input  logic              s_valid,
  input  logic [BEAT_W-1:0] s_data,
  output logic              s_ready,
  output logic [WIDTH:0]    data,
  output logic [NUM_PE-1:0] wr_pe,
  output logic [CTX_AW-1:0] wr_addr,
  output logic              start,
  output logic              busy,
  output logic              cfg_err
);

  localparam int PE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [1:0]        state_q, state_d;
  logic [PE_W-1:0]   pe_idx_q, pe_idx_d;
  logic [CTX_AW-1:0] ctx_addr_q, ctx_addr_d;
  logic [WIDTH:0]    data_q, data_d;
  logic              cfg_err_q, cfg_err_d;

  logic              beat_en;
  logic              asm_clr;
  logic              word_done;
  logic [WORD_W-1:0] word;
  logic              par_err;
  logic              last_ctx;
  logic              last_word;
  logic              unused_word_bits;

  assign beat_en = (state_q == ST_FILL) && s_valid;
  assign asm_clr = (state_q == ST_IDLE) && load_req;

  ctx_beat_assembler u_asm (
    .CLK       (CLK),
    .RST       (RST),
    .clr       (asm_clr),
    .beat_en   (beat_en),
    .beat_data (s_data),
    .word_done (word_done),
    .word      (word)
  );

  // Bits above the context word are only meaningful as the parity bit.
  assign unused_word_bits = ^word;

`ifdef CTX_PARITY_EN
  assign par_err = (state_q == ST_WRITE) && !ctx_parity_ok(word, WIDTH);
`else
  assign par_err = 1'b0;
`endif

  assign last_ctx  = (ctx_addr_q == CTX_AW'(CTX_DEPTH - 1));
  assign last_word = last_ctx && (pe_idx_q == PE_W'(NUM_PE - 1));

  always_comb begin
    state_d    = state_q;
    pe_idx_d   = pe_idx_q;
    ctx_addr_d = ctx_addr_q;
    data_d     = data_q;
    cfg_err_d  = cfg_err_q;
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          state_d    = ST_FILL;
          pe_idx_d   = '0;
          ctx_addr_d = '0;
          cfg_err_d  = 1'b0;
        end
      end
      ST_FILL: begin
        if (word_done) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        data_d = word[WIDTH:0];
        if (par_err) cfg_err_d = 1'b1;
        // Counters advance even when a corrupt word is dropped.
        if (last_ctx) begin
          ctx_addr_d = '0;
          pe_idx_d   = pe_idx_q + PE_W'(1);
        end else begin
          ctx_addr_d = ctx_addr_q + CTX_AW'(1);
        end
        state_d = last_word ? ST_DONE : ST_FILL;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      pe_idx_q   <= '0;
      ctx_addr_q <= '0;
      data_q     <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pe_idx_q   <= pe_idx_d;
      ctx_addr_q <= ctx_addr_d;
      data_q     <= data_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign s_ready = (state_q == ST_FILL);
  assign busy    = (state_q != ST_IDLE);
  assign data    = (state_q == ST_WRITE) ? word[WIDTH:0] : data_q;
  assign wr_pe   = ((state_q == ST_WRITE) && !par_err) ? (NUM_PE'(1) << pe_idx_q) : '0;
  assign wr_addr = ctx_addr_q;
  assign start   = (state_q == ST_DONE) && !cfg_err_q;

`ifdef CTX_PARITY_EN
  assign cfg_err = cfg_err_q | par_err;
`else
  assign cfg_err = 1'b0;
`endif

endmodule

// File: tb/tb_context_loader.sv
// Directed bench for context_loader with a 2-PE x 2-context geometry (16 beats per load).
module tb_context_loader;

  logic        CLK;
  logic        RST;
  logic        load_req;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic [120:0] data;
  logic [1:0]  wr_pe;
  logic [0:0]  wr_addr;
  logic        start;
  logic        busy;
  logic        cfg_err;

  context_loader #(
    .WIDTH     (120),
    .NUM_PE    (2),
    .CTX_DEPTH (2),
    .CTX_AW    (1)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .load_req (load_req),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .data     (data),
    .wr_pe    (wr_pe),
    .wr_addr  (wr_addr),
    .start    (start),
    .busy     (busy),
    .cfg_err  (cfg_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;
  int acc_n = 0;
  int wr_n = 0;
  int start_n = 0;
  int start_cyc = 0;
  logic [1:0]   wr_pe_log   [8];
  logic [0:0]   wr_addr_log [8];
  logic [120:0] wr_data_log [8];
  int           wr_cyc_log  [8];
  logic a;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] raw_beat(input int load, input int idx);
    logic [31:0] v;
    int w;
    int s;
    w = idx / 4;
    s = idx % 4;
    if (load == 0) v = 32'(idx + 1);
    else           v = {8'(load), 8'(w), 8'(s), 8'h5A};
    if (s == 3 && load != 0) v[31:25] = 7'h55;
    return v;
  endfunction

  function automatic logic [120:0] exp_word(input int load, input int w);
    logic [31:0] b3;
    b3 = raw_beat(load, 4*w + 3);
    return {b3[24:0], raw_beat(load, 4*w + 2), raw_beat(load, 4*w + 1), raw_beat(load, 4*w)};
  endfunction

  function automatic logic [31:0] beat_val(input int load, input int idx);
    logic [31:0] v;
    v = raw_beat(load, idx);
`ifdef CTX_PARITY_EN
    if (idx % 4 == 3) begin
      v[31] = ~^exp_word(load, idx / 4);
      if (load == 4 && idx == 11) v[31] = ~v[31];
    end
`endif
    return v;
  endfunction

  task automatic cyc(output logic acc);
    acc = s_valid && s_ready;
    @(posedge CLK);
    #1;
    cyc_n++;
    if (acc) acc_n++;
    if (wr_pe != '0) begin
      chk("wr_ready_low", {127'b0, s_ready}, 128'b0);
      if (wr_n < 8) begin
        wr_pe_log[wr_n]   = wr_pe;
        wr_addr_log[wr_n] = wr_addr;
        wr_data_log[wr_n] = data;
        wr_cyc_log[wr_n]  = cyc_n;
      end
      wr_n++;
    end
    if (start) begin
      start_n++;
      start_cyc = cyc_n;
    end
  endtask

  task automatic feed(input int load, input int first, input int last, input int gap, input int budget);
    int idx;
    int n;
    logic acc;
    idx = first;
    n = 0;
    while (idx < last && n < budget) begin
      s_valid = (gap == 0) || ((n % gap) != gap - 1);
      s_data  = beat_val(load, idx);
      cyc(acc);
      n++;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    chk("feed_timeout", idx, last);
  endtask

  task automatic begin_load();
    wr_n = 0;
    acc_n = 0;
    load_req = 1'b1;
    cyc(a);
    load_req = 1'b0;
  endtask

  task automatic finish_load(input int load, input int starts_exp);
    cyc(a);
    chk("done_start", start, 1);
    chk("done_busy", busy, 1);
    cyc(a);
    chk("idle_start", start, 0);
    chk("idle_busy", busy, 0);
    chk("n_writes", wr_n, 4);
    chk("n_beats", acc_n, 16);
    for (int i = 0; i < 4 && i < wr_n; i++) begin
      chk($sformatf("wr_pe_%0d_%0d", load, i), wr_pe_log[i], (i < 2) ? 2'b01 : 2'b10);
      chk($sformatf("wr_addr_%0d_%0d", load, i), wr_addr_log[i], i % 2);
      chk($sformatf("wr_data_%0d_%0d", load, i), wr_data_log[i], exp_word(load, i));
    end
    chk("start_latency", start_cyc, wr_cyc_log[3] + 1);
    chk("start_count", start_n, starts_exp);
    chk("data_hold", data, exp_word(load, 3));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1;
    load_req = 1'b0;
    s_valid = 1'b1;
    s_data = 32'hDEAD_BEEF;

    // Reset held with a valid source: nothing may be consumed or started
    for (int i = 0; i < 3; i++) begin
      cyc(a);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_wr_pe", wr_pe, 0);
      chk("rst_start", start, 0);
      chk("rst_busy", busy, 0);
    end
    chk("rst_data", data, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_cfg_err", cfg_err, 0);
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(a);
      chk("idle_s_ready", s_ready, 0);
      chk("idle_busy0", busy, 0);
    end

    // Load 0: single word path, then backpressure with s_valid held high
    s_valid = 1'b0;
    begin_load();
    chk("fill_busy", busy, 1);
    chk("fill_ready", s_ready, 1);
    feed(0, 0, 4, 0, 20);
    chk("w0_wr_pe", wr_pe, 2'b01);
    chk("w0_wr_addr", wr_addr, 0);
    chk("w0_lo", data[31:0], 32'd1);
    chk("w0_hi", data[120:96], 25'd4);
    chk("w0_full", data, {25'd4, 32'd3, 32'd2, 32'd1});
    feed(0, 4, 16, 0, 100);
    finish_load(0, 1);

    // Load 1: source gaps every 3rd cycle, junk above bit 120 must be dropped
    begin_load();
    feed(1, 0, 16, 3, 200);
    finish_load(1, 2);

    // Load 2: reset after 6 beats
    begin_load();
    feed(2, 0, 6, 0, 50);
    RST = 1'b1;
    #1;
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_pe", wr_pe, 0);
    chk("mid_rst_data", data, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    chk("mid_rst_start", start, 0);
    cyc(a);
    cyc(a);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) cyc(a);
    chk("no_stray_start", start_n, 2);

    // Load 3: restart from PE0/ctx0 after the abandoned load
    begin_load();
    feed(3, 0, 16, 3, 200);
    finish_load(3, 3);

`ifdef CTX_PARITY_EN
    // Load 4: word 2 carries a flipped parity bit
    begin_load();
    feed(4, 0, 12, 0, 100);
    chk("par_drop_wr_pe", wr_pe, 0);
    chk("par_cfg_err", cfg_err, 1);
    chk("par_wr_addr", wr_addr, 0);
    feed(4, 12, 16, 0, 50);
    chk("par_w3_wr_pe", wr_pe, 2'b10);
    cyc(a);
    chk("par_no_start", start, 0);
    cyc(a);
    chk("par_idle_busy", busy, 0);
    chk("par_err_sticky", cfg_err, 1);
    chk("par_n_writes", wr_n, 3);
    chk("par_start_count", start_n, 3);
    begin_load();
    chk("par_err_cleared", cfg_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
